register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32 x 32-bit general-purpose register file for the multi-cycle MIPS datapath.
- Two asynchronous (combinational) read ports feed the ALU operand registers A and B; one synchronous write port carries write-back.
- Register 0 is hardwired to zero, per the MIPS ISA.

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 5, width of each address port.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- we3  input  1  write enable for port 3.
- address1  input  ADDR_W  read port 1 register index (rs).
- address2  input  ADDR_W  read port 2 register index (rt).
- address3  input  ADDR_W  write port register index (rd/rt).
- wdata3  input  DATA_W  write data.
- rdata1  output  DATA_W  contents of register[address1].
- rdata2  output  DATA_W  contents of register[address2].

Behaviour:
- Storage: NUM_REGS x DATA_W flops, index 0..NUM_REGS-1.
- Reset: on a rising clk edge with reset=1, every register is cleared to 0. While reset is asserted, rdata1 and rdata2 read 0 from the edge onward. Reset has priority over a simultaneous write.
- Write: on a rising clk edge with reset=0, we3=1 and address3!=0, register[address3] <= wdata3. The new value is visible on the read ports immediately after that edge (1-cycle write latency).
- we3=0: no register changes, regardless of address3 or wdata3.
- Writes to address3=0 are discarded; register 0 always reads 0.
- Reads are purely combinational:
  - rdata1 = (address1==0) ? 0 : register[address1]
  - rdata2 likewise for address2.
  - Outputs change in the same cycle the address changes.
- Both read ports may address the same register, and either may equal address3.
- Default read-during-write: a read port returns the old value until the write edge, then the new value.
- Pre-reset contents: X in simulation. The reset value is defined only after the first reset edge.
- No X on outputs after reset with known addresses.
- No handshake and no stalls; the block accepts one write per cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If we3=1, reset=0, address3!=0 and addressN==address3, then rdataN = wdata3 combinationally in the same cycle, before the edge.
- Not defined: no forwarding; reads return stored contents only, as above.
- Register-0 and reset rules hold in both builds.

Decomposition:
- Shared package mips_pkg holds:
  - constants: REG_DATA_W=32, REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0
  - typedefs: reg_addr_t (logic [4:0]) and word_t (logic [31:0])
- One natural sub-module: regfile_read_port. It is instantiated twice and contains the mux, the zero-register override and the optional bypass compare.
- The write logic and storage stay in register_file.

Test Plan:
- Reset: assert reset for 2 edges, then read addresses 0, 1 and 31 -> all read 0x00000000.
- Basic write/read: clk period 40 ns, we3=0 for 100 ns, then we3=1, address3=1, wdata3=15, address1=1 -> rdata1 = 0x0000000F after the first subsequent rising edge and stays 15. Before we3 rises it reads 0.
- Disabled write: we3=0, address3=5, wdata3=0xDEADBEEF, 3 edges -> register 5 reads 0.
- Zero register: we3=1, address3=0, wdata3=0xFFFFFFFF, then address1=0 and address2=0 -> both read 0.
- Dual read and reset priority:
  - Write r2=0xA5A5A5A5 and r31=0x12345678, address1=2, address2=31 -> rdata1=0xA5A5A5A5, rdata2=0x12345678.
  - Then reset=1 with we3=1, address3=2, wdata3=7 -> rdata1=0 after the edge.
- Read-during-write: address1=address3=3, r3 holds 1, we3=1, wdata3=9:
  - Before the edge: rdata1 = 1 in the default build, 9 with REGFILE_BYPASS_EN.
  - After the edge: 9 in both builds.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS datapath.
// The register file and its read ports take their default widths from here.
package mips_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Index of the hardwired-zero register ($zero).
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the MIPS register file.
// Selects a register from the flattened storage vector and forces the
// hardwired-zero register to read 0.
// Optional build macro: REGFILE_BYPASS_EN. When defined, the port also
// forwards the in-flight write data when the write address matches, so a
// read in the same cycle as a write already sees the new value.
// There is no handshake: the port is a pure function of its inputs.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int N_REGS   = 32
) (
`ifdef REGFILE_BYPASS_EN
    input  logic                     byp_en_i,
    input  logic [ADDR_W-1:0]        byp_addr_i,
    input  logic [DATA_W-1:0]        byp_data_i,
`endif
    input  logic [N_REGS*DATA_W-1:0] regs_flat_i,
    input  logic [ADDR_W-1:0]        address_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] stored_d;

    // Plain mux over every stored register (register 0 included so all
    // storage bits are consumed; its value is overridden below anyway).
    always_comb begin
        stored_d = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (address_i == ADDR_W'(i)) begin
                stored_d = regs_flat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Final output: optional forwarding, then the $zero override which
    // always wins regardless of build.
    always_comb begin
        rdata_o = stored_d;
`ifdef REGFILE_BYPASS_EN
        if (byp_en_i && (address_i == byp_addr_i)) begin
            rdata_o = byp_data_i;
        end
`endif
        if (address_i == ADDR_W'(ZERO_REG)) begin
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit general-purpose register file for the multi-cycle MIPS
// datapath: two combinational read ports (rs -> A, rt -> B) and one
// synchronous write port carrying write-back.
// Optional build macro: REGFILE_BYPASS_EN (write-through forwarding on
// both read ports). Without it, reads return stored contents only.
// Reset is synchronous and active high; it clears every register and
// takes priority over a simultaneous write.
// There is no handshake and no stall: one write may be accepted per cycle.
// NUM_REGS must equal 2**ADDR_W so every address selects a real register.
module register_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::REG_DATA_W,
    parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [ADDR_W-1:0] address3,
    input  logic [DATA_W-1:0] wdata3,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0]          regs_q [NUM_REGS];
    logic [DATA_W-1:0]          regs_d [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic                       wr_en;

    // A write is real only when enabled and not aimed at $zero; reset
    // priority is handled in the register process.
    assign wr_en = we3 && (address3 != ADDR_W'(ZERO_REG));

    // Next-state storage: copy of current contents with the write applied.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[address3] = wdata3;
        end
    end

    // Storage update: reset clears everything and overrides any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Flatten storage into one vector shared by both read ports.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_en;
    // Forwarding is suppressed during reset so reads never see data that
    // the reset edge is about to discard.
    assign byp_en = wr_en && !reset;
`endif

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_REGS (NUM_REGS)
    ) u_read_port1 (
`ifdef REGFILE_BYPASS_EN
        .byp_en_i    (byp_en),
        .byp_addr_i  (address3),
        .byp_data_i  (wdata3),
`endif
        .regs_flat_i (regs_flat),
        .address_i   (address1),
        .rdata_o     (rdata1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_REGS (NUM_REGS)
    ) u_read_port2 (
`ifdef REGFILE_BYPASS_EN
        .byp_en_i    (byp_en),
        .byp_addr_i  (address3),
        .byp_data_i  (wdata3),
`endif
        .regs_flat_i (regs_flat),
        .address_i   (address2),
        .rdata_o     (rdata2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, basic write/read, disabled
// write, $zero, dual read, reset priority, read-during-write and a short
// burst of writes checked through an expected-value queue.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        we3;
    logic [4:0]  address1;
    logic [4:0]  address2;
    logic [4:0]  address3;
    logic [31:0] wdata3;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [31:0] exp_q[$];

    register_file dut (
        .clk      (clk),
        .reset    (reset),
        .we3      (we3),
        .address1 (address1),
        .address2 (address2),
        .address3 (address3),
        .wdata3   (wdata3),
        .rdata1   (rdata1),
        .rdata2   (rdata2)
    );

    // Clock/reset block: 40 ns period.
    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge and move 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        we3      = 1'b1;
        address3 = addr;
        wdata3   = data;
        tick();
        we3      = 1'b0;
    endtask

    logic [4:0]  burst_addr [4];
    logic [31:0] burst_data [4];
    logic [31:0] rdw_pre;
    logic [31:0] basic_pre;

    initial begin
        burst_addr[0] = 5'd10; burst_data[0] = 32'h0000_0001;
        burst_addr[1] = 5'd11; burst_data[1] = 32'h8000_0000;
        burst_addr[2] = 5'd17; burst_data[2] = 32'hCAFE_F00D;
        burst_addr[3] = 5'd30; burst_data[3] = 32'h5A5A_0F0F;
`ifdef REGFILE_BYPASS_EN
        rdw_pre   = 32'd9;
        basic_pre = 32'd15;
`else
        rdw_pre   = 32'd1;
        basic_pre = 32'd0;
`endif

        reset    = 1'b1;
        we3      = 1'b0;
        address1 = 5'd0;
        address2 = 5'd0;
        address3 = 5'd0;
        wdata3   = 32'h0;

        // Reset for two edges, then release.
        tick();
        tick();
        reset    = 1'b0;
        address1 = 5'd0;
        address2 = 5'd1;
        #1;
        check("reset_r0", rdata1, 32'h0);
        check("reset_r1", rdata2, 32'h0);
        address1 = 5'd31;
        #1;
        check("reset_r31", rdata1, 32'h0);

        // Basic write/read: idle 100 ns with we3 low, then write r1=15.
        address1 = 5'd1;
        #100;
        check("basic_idle", rdata1, 32'h0);
        we3      = 1'b1;
        address3 = 5'd1;
        wdata3   = 32'd15;
        #1;
        check("basic_pre_edge", rdata1, basic_pre);
        tick();
        check("basic_post_edge", rdata1, 32'h0000_000F);
        we3 = 1'b0;
        tick();
        check("basic_hold", rdata1, 32'h0000_000F);

        // Disabled write: nothing lands in r5.
        we3      = 1'b0;
        address3 = 5'd5;
        wdata3   = 32'hDEAD_BEEF;
        address1 = 5'd5;
        #1;
        check("disabled_pre", rdata1, 32'h0);
        tick();
        tick();
        tick();
        check("disabled_r5", rdata1, 32'h0);

        // $zero: write all-ones to r0, both ports read 0 before and after.
        address1 = 5'd0;
        address2 = 5'd0;
        we3      = 1'b1;
        address3 = 5'd0;
        wdata3   = 32'hFFFF_FFFF;
        #1;
        check("zero_pre_p1", rdata1, 32'h0);
        tick();
        we3 = 1'b0;
        check("zero_p1", rdata1, 32'h0);
        check("zero_p2", rdata2, 32'h0);

        // Dual read of two distinct registers.
        write_reg(5'd2,  32'hA5A5_A5A5);
        write_reg(5'd31, 32'h1234_5678);
        address1 = 5'd2;
        address2 = 5'd31;
        #1;
        check("dual_p1_r2", rdata1, 32'hA5A5_A5A5);
        check("dual_p2_r31", rdata2, 32'h1234_5678);
        address1 = 5'd31;
        address2 = 5'd31;
        #1;
        check("same_reg_p1", rdata1, 32'h1234_5678);
        check("same_reg_p2", rdata2, 32'h1234_5678);

        // Reset priority over a simultaneous write (no forwarding in reset).
        address1 = 5'd2;
        address2 = 5'd31;
        reset    = 1'b1;
        we3      = 1'b1;
        address3 = 5'd2;
        wdata3   = 32'd7;
        #1;
        check("rst_prio_pre", rdata1, 32'hA5A5_A5A5);
        tick();
        check("rst_prio_p1", rdata1, 32'h0);
        check("rst_prio_p2", rdata2, 32'h0);
        reset = 1'b0;
        we3   = 1'b0;
        #1;
        check("rst_prio_after", rdata1, 32'h0);

        // Read-during-write on r3 (port 1); port 2 watches untouched r4.
        write_reg(5'd3, 32'd1);
        address1 = 5'd3;
        address2 = 5'd4;
        we3      = 1'b1;
        address3 = 5'd3;
        wdata3   = 32'd9;
        #1;
        check("rdw_pre_edge", rdata1, rdw_pre);
        check("rdw_other_port", rdata2, 32'h0);
        tick();
        we3 = 1'b0;
        check("rdw_post_edge", rdata1, 32'd9);
        check("rdw_other_after", rdata2, 32'h0);

        // Burst of writes, checked in order through the expected queue.
        for (int i = 0; i < 4; i++) begin
            write_reg(burst_addr[i], burst_data[i]);
            exp_q.push_back(burst_data[i]);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_v;
            exp_v    = exp_q.pop_front();
            address1 = burst_addr[i];
            address2 = burst_addr[3 - i];
            #1;
            check($sformatf("burst_p1_%0d", i), rdata1, exp_v);
            check($sformatf("burst_p2_%0d", i), rdata2, burst_data[3 - i]);
        end
        address1 = 5'd1;
        #1;
        check("r1_retained", rdata1, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
